// File: rtl/tcb_lite_lib_register_response.sv
// TCB lite response-path register slice: request/handshake pass through, response delayed DLY_ADD cycles.
// Optional build macro TCB_LITE_LIB_RSP_HOLD_EN: stage data registers load only on valid responses.

module tcb_lite_lib_register_response_stage #(
    parameter int DAT_W = 32,
    parameter int STS_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_vld,
    input  logic [DAT_W-1:0] src_rdt,
    input  logic [STS_W-1:0] src_sts,
    input  logic             src_err,
    output logic             dst_vld,
    output logic [DAT_W-1:0] dst_rdt,
    output logic [STS_W-1:0] dst_sts,
    output logic             dst_err
);

    logic ld;

`ifdef TCB_LITE_LIB_RSP_HOLD_EN
    // hold the last valid response between transfers to cut toggling
    assign ld = src_vld;
`else
    assign ld = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_vld <= 1'b0;
            dst_rdt <= '0;
            dst_sts <= '0;
            dst_err <= 1'b0;
        end else begin
            dst_vld <= src_vld;
            if (ld) begin
                dst_rdt <= src_rdt;
                dst_sts <= src_sts;
                dst_err <= src_err;
            end
        end
    end

endmodule

module tcb_lite_lib_register_response #(
    parameter int DLY_ADD = 1,
    parameter int MAN_DLY = 1,
    parameter int SUB_DLY = MAN_DLY + DLY_ADD,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int BYT_W   = DAT_W / 8,
    parameter int SIZ_W   = 2,
    parameter int CTL_W   = 1,
    parameter int STS_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    // manager side
    input  logic             sub_vld,
    input  logic             sub_lck,
    input  logic             sub_ndn,
    input  logic             sub_wen,
    input  logic             sub_ren,
    input  logic [CTL_W-1:0] sub_ctl,
    input  logic [ADR_W-1:0] sub_adr,
    input  logic [SIZ_W-1:0] sub_siz,
    input  logic [BYT_W-1:0] sub_byt,
    input  logic [DAT_W-1:0] sub_wdt,
    output logic             sub_rdy,
    output logic [DAT_W-1:0] sub_rdt,
    output logic [STS_W-1:0] sub_sts,
    output logic             sub_err,
    output logic             sub_rsp_vld,
    // subordinate side
    output logic             man_vld,
    output logic             man_lck,
    output logic             man_ndn,
    output logic             man_wen,
    output logic             man_ren,
    output logic [CTL_W-1:0] man_ctl,
    output logic [ADR_W-1:0] man_adr,
    output logic [SIZ_W-1:0] man_siz,
    output logic [BYT_W-1:0] man_byt,
    output logic [DAT_W-1:0] man_wdt,
    input  logic             man_rdy,
    input  logic [DAT_W-1:0] man_rdt,
    input  logic [STS_W-1:0] man_sts,
    input  logic             man_err
);

    if (DLY_ADD < 1 || DLY_ADD > 4) begin : g_chk_add
        $error("tcb_lite_lib_register_response: DLY_ADD=%0d outside 1..4", DLY_ADD);
    end
    if (SUB_DLY != MAN_DLY + DLY_ADD) begin : g_chk_dly
        $error("tcb_lite_lib_register_response: SUB_DLY=%0d != MAN_DLY=%0d + DLY_ADD=%0d",
               SUB_DLY, MAN_DLY, DLY_ADD);
    end

    assign man_vld = sub_vld;
    assign man_lck = sub_lck;
    assign man_ndn = sub_ndn;
    assign man_wen = sub_wen;
    assign man_ren = sub_ren;
    assign man_ctl = sub_ctl;
    assign man_adr = sub_adr;
    assign man_siz = sub_siz;
    assign man_byt = sub_byt;
    assign man_wdt = sub_wdt;
    assign sub_rdy = man_rdy;

    logic trn;
    logic rsp_vld_man;

    assign trn = man_vld & man_rdy;

    // tail of the tracking chain marks the cycle man_* response is valid
    if (MAN_DLY == 0) begin : g_trk0
        assign rsp_vld_man = trn;
    end else begin : g_trk
        logic [MAN_DLY-1:0] trn_pipe;
        always_ff @(posedge clk) begin
            if (rst) begin
                trn_pipe <= '0;
            end else begin
                trn_pipe[0] <= trn;
                for (int i = 1; i < MAN_DLY; i++) trn_pipe[i] <= trn_pipe[i-1];
            end
        end
        assign rsp_vld_man = trn_pipe[MAN_DLY-1];
    end

    logic [DLY_ADD:0]            vld_pipe;
    logic [DLY_ADD:0][DAT_W-1:0] rdt_pipe;
    logic [DLY_ADD:0][STS_W-1:0] sts_pipe;
    logic [DLY_ADD:0]            err_pipe;

    assign vld_pipe[0] = rsp_vld_man;
    assign rdt_pipe[0] = man_rdt;
    assign sts_pipe[0] = man_sts;
    assign err_pipe[0] = man_err;

    for (genvar i = 0; i < DLY_ADD; i++) begin : g_stg
        tcb_lite_lib_register_response_stage #(
            .DAT_W (DAT_W),
            .STS_W (STS_W)
        ) u_stg (
            .clk     (clk),
            .rst     (rst),
            .src_vld (vld_pipe[i]),
            .src_rdt (rdt_pipe[i]),
            .src_sts (sts_pipe[i]),
            .src_err (err_pipe[i]),
            .dst_vld (vld_pipe[i+1]),
            .dst_rdt (rdt_pipe[i+1]),
            .dst_sts (sts_pipe[i+1]),
            .dst_err (err_pipe[i+1])
        );
    end

    assign sub_rsp_vld = vld_pipe[DLY_ADD];
    assign sub_rdt     = rdt_pipe[DLY_ADD];
    assign sub_sts     = sts_pipe[DLY_ADD];
    assign sub_err     = err_pipe[DLY_ADD];

endmodule

// File: tb/tb_tcb_lite_lib_register_response.sv
// Bench for tcb_lite_lib_register_response: DLY_ADD=1 and DLY_ADD=3 instances share one stimulus stream.
module tb_tcb_lite_lib_register_response;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sub_vld, sub_lck, sub_ndn, sub_wen, sub_ren;
    logic [0:0]  sub_ctl;
    logic [31:0] sub_adr, sub_wdt;
    logic [1:0]  sub_siz;
    logic [3:0]  sub_byt;
    logic        man_rdy, man_err;
    logic [31:0] man_rdt;
    logic [1:0]  man_sts;

    logic        d1_man_vld, d1_man_lck, d1_man_ndn, d1_man_wen, d1_man_ren;
    logic [0:0]  d1_man_ctl;
    logic [31:0] d1_man_adr, d1_man_wdt, d1_sub_rdt;
    logic [1:0]  d1_man_siz, d1_sub_sts;
    logic [3:0]  d1_man_byt;
    logic        d1_sub_rdy, d1_sub_err, d1_sub_rsp_vld;

    logic        d3_man_vld, d3_man_lck, d3_man_ndn, d3_man_wen, d3_man_ren;
    logic [0:0]  d3_man_ctl;
    logic [31:0] d3_man_adr, d3_man_wdt, d3_sub_rdt;
    logic [1:0]  d3_man_siz, d3_sub_sts;
    logic [3:0]  d3_man_byt;
    logic        d3_sub_rdy, d3_sub_err, d3_sub_rsp_vld;

    tcb_lite_lib_register_response #(.DLY_ADD(1), .MAN_DLY(1), .STS_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_lck(sub_lck), .sub_ndn(sub_ndn), .sub_wen(sub_wen),
        .sub_ren(sub_ren), .sub_ctl(sub_ctl), .sub_adr(sub_adr), .sub_siz(sub_siz),
        .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdy(d1_sub_rdy), .sub_rdt(d1_sub_rdt),
        .sub_sts(d1_sub_sts), .sub_err(d1_sub_err), .sub_rsp_vld(d1_sub_rsp_vld),
        .man_vld(d1_man_vld), .man_lck(d1_man_lck), .man_ndn(d1_man_ndn), .man_wen(d1_man_wen),
        .man_ren(d1_man_ren), .man_ctl(d1_man_ctl), .man_adr(d1_man_adr), .man_siz(d1_man_siz),
        .man_byt(d1_man_byt), .man_wdt(d1_man_wdt), .man_rdy(man_rdy), .man_rdt(man_rdt),
        .man_sts(man_sts), .man_err(man_err)
    );

    tcb_lite_lib_register_response #(.DLY_ADD(3), .MAN_DLY(1), .STS_W(2)) dut3 (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_lck(sub_lck), .sub_ndn(sub_ndn), .sub_wen(sub_wen),
        .sub_ren(sub_ren), .sub_ctl(sub_ctl), .sub_adr(sub_adr), .sub_siz(sub_siz),
        .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdy(d3_sub_rdy), .sub_rdt(d3_sub_rdt),
        .sub_sts(d3_sub_sts), .sub_err(d3_sub_err), .sub_rsp_vld(d3_sub_rsp_vld),
        .man_vld(d3_man_vld), .man_lck(d3_man_lck), .man_ndn(d3_man_ndn), .man_wen(d3_man_wen),
        .man_ren(d3_man_ren), .man_ctl(d3_man_ctl), .man_adr(d3_man_adr), .man_siz(d3_man_siz),
        .man_byt(d3_man_byt), .man_wdt(d3_man_wdt), .man_rdy(man_rdy), .man_rdt(man_rdt),
        .man_sts(man_sts), .man_err(man_err)
    );

    typedef struct {
        int          due;
        logic [31:0] rdt;
        logic [1:0]  sts;
        logic        err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] man_hist [0:4095];
    logic        rst_hist [0:4095];
    logic [31:0] held1 = '0, held3 = '0;
    logic [31:0] idle_rdt = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_rdt;
    logic [1:0]  pend_sts;
    logic        pend_err;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, want);
        end
    endtask

    // free-running (non-hold) output: man_rdt delayed d cycles, zeroed by any reset in that window
    function automatic logic [31:0] mirror(input int k, input int d);
        for (int j = (k - d < 0 ? 0 : k - d); j < k; j++) if (rst_hist[j]) return '0;
        return man_hist[k-d];
    endfunction

    task automatic tick(input logic vld, input logic wen, input logic [31:0] adr,
                        input logic [31:0] wdt, input logic rdy, input logic [31:0] r_rdt,
                        input logic [1:0] r_sts, input logic r_err, input logic r);
        exp_t e;
        @(negedge clk);
        rst = r;
        sub_vld = vld; sub_wen = wen; sub_ren = vld & ~wen;
        sub_adr = adr; sub_wdt = wdt; sub_lck = adr[2]; sub_ndn = adr[3];
        sub_ctl = adr[4]; sub_siz = 2'd2; sub_byt = adr[3:0] | 4'h1;
        man_rdy = rdy;
        if (pend) begin
            man_rdt = pend_rdt; man_sts = pend_sts; man_err = pend_err;
        end else begin
            man_rdt = idle_rdt; man_sts = 2'd0; man_err = 1'b0;
        end
        man_hist[cyc] = man_rdt;
        rst_hist[cyc] = r;
        #1;
        chk("d1 sub_rdy", {95'd0, d1_sub_rdy}, {95'd0, rdy});
        chk("d3 sub_rdy", {95'd0, d3_sub_rdy}, {95'd0, rdy});
        chk("d1 fwd", {d1_man_vld, d1_man_lck, d1_man_ndn, d1_man_wen, d1_man_ren, d1_man_ctl,
                       d1_man_adr, d1_man_siz, d1_man_byt, d1_man_wdt},
                      {vld, adr[2], adr[3], wen, vld & ~wen, adr[4], adr, 2'd2,
                       adr[3:0] | 4'h1, wdt});
        chk("d3 fwd", {d3_man_vld, d3_man_lck, d3_man_ndn, d3_man_wen, d3_man_ren, d3_man_ctl,
                       d3_man_adr, d3_man_siz, d3_man_byt, d3_man_wdt},
                      {vld, adr[2], adr[3], wen, vld & ~wen, adr[4], adr, 2'd2,
                       adr[3:0] | 4'h1, wdt});
        if (cyc >= 1) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("d1 rsp_vld", {95'd0, d1_sub_rsp_vld}, 96'd1);
                chk("d1 rsp", {d1_sub_rdt, d1_sub_sts, d1_sub_err}, {e.rdt, e.sts, e.err});
                held1 = e.rdt;
            end else begin
                chk("d1 idle rsp_vld", {95'd0, d1_sub_rsp_vld}, 96'd0);
`ifdef TCB_LITE_LIB_RSP_HOLD_EN
                chk("d1 hold rdt", {64'd0, d1_sub_rdt}, {64'd0, held1});
`else
                chk("d1 mirror rdt", {64'd0, d1_sub_rdt}, {64'd0, mirror(cyc, 1)});
`endif
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                e = q3.pop_front();
                chk("d3 rsp_vld", {95'd0, d3_sub_rsp_vld}, 96'd1);
                chk("d3 rsp", {d3_sub_rdt, d3_sub_sts, d3_sub_err}, {e.rdt, e.sts, e.err});
                held3 = e.rdt;
            end else begin
                chk("d3 idle rsp_vld", {95'd0, d3_sub_rsp_vld}, 96'd0);
`ifdef TCB_LITE_LIB_RSP_HOLD_EN
                chk("d3 hold rdt", {64'd0, d3_sub_rdt}, {64'd0, held3});
`else
                chk("d3 mirror rdt", {64'd0, d3_sub_rdt}, {64'd0, mirror(cyc, 3)});
`endif
            end
        end
        @(posedge clk);
        // bench subordinate answers one cycle after every handshake
        pend = vld & rdy;
        pend_rdt = r_rdt; pend_sts = r_sts; pend_err = r_err;
        if (r) begin
            q1.delete(); q3.delete();
            held1 = '0; held3 = '0;
        end else if (vld & rdy) begin
            q1.push_back('{cyc + 2, r_rdt, r_sts, r_err});
            q3.push_back('{cyc + 4, r_rdt, r_sts, r_err});
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 2'd0, 1'b0, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

        idle(2, 1'b1);
        idle(1, 1'b0);

        // single read
        tick(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0);
        idle(5, 1'b0);

        // back-to-back reads, varied status
        for (int i = 0; i < 4; i++)
            tick(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, vals[i], 2'(i), 1'b0, 1'b0);
        idle(5, 1'b0);

        // read stalled by man_rdy low for 3 cycles
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hBAD0BAD0, 2'd1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'hCAFE0003, 2'd1, 1'b0, 1'b0);
        idle(5, 1'b0);

        // write returning an error
        tick(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h0, 2'd2, 1'b1, 1'b0);
        idle(5, 1'b0);

        // three reads in flight, then a one-cycle reset
        tick(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'hA1, 2'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 32'hA2, 2'd2, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h38, 32'h0, 1'b1, 32'hA3, 2'd3, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(6, 1'b0);

        // handshake during reset is dropped; first cycle after release is tracked
        tick(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hB0B0B0B0, 2'd0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'hC1C1C1C1, 2'd1, 1'b0, 1'b0);
        idle(5, 1'b0);

        // read then idle while man_rdt toggles
        tick(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 32'h5A5A5A5A, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle_rdt = i[0] ? 32'hFFFF0000 : 32'h0000FFFF;
            idle(1, 1'b0);
        end
        idle_rdt = '0;

        // random traffic with random stalls
        for (int i = 0; i < 30; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFC,
                 $urandom, 1'($urandom_range(0, 3) != 0), $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        idle(6, 1'b0);

        chk("d1 drained", 96'(q1.size()), 96'd0);
        chk("d3 drained", 96'(q3.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcb_lite_lib_register_response.md
# tcb_lite_lib_register_response

Response-path register slice for TCB lite. It sits directly downstream of a manager, or of a passthrough stage, and directly upstream of the subordinate device. Request and handshake signals pass through combinationally. The response (`rdt`, `sts`, `err`) goes through `DLY_ADD` register stages, which breaks long read-data timing paths. The subordinate-side response latency is the manager-side latency plus `DLY_ADD`.

## Interface
Parameters:
- `DLY_ADD`, default 1: number of response register stages; legal range 1..4.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `sub`  `tcb_lite_if.sub`  interface  upstream side; the manager device connects here.
- `man`  `tcb_lite_if.man`  interface  downstream side; the subordinate device connects here.

Elaboration checks:
- `sub.CFG` equals `man.CFG` in every field except the response delay.
- `sub.CFG.HSK.DLY == man.CFG.HSK.DLY + DLY_ADD`.
- Any violation raises `$error`.

## Operation
Request and handshake path, combinational:
- `man.vld = sub.vld` and `sub.rdy = man.rdy`.
- All request fields (`lck`, `ndn`, `wen`, `ren`, `ctl`, `adr`, `siz`, `byt`, `wdt`) are forwarded unchanged.

Transfer tracking:
- `trn = man.vld & man.rdy`.
- A shift register of length `man.CFG.HSK.DLY` carries `trn`. Its tail marks the cycle in which `man.rsp` is valid (`rsp_vld_man`).
- If `man.CFG.HSK.DLY = 0`, then `rsp_vld_man = trn` directly.

Response pipeline:
- There are `DLY_ADD` stages. Each stage holds a valid bit plus `rdt`, `sts` and `err`.
- The valid bit shifts every cycle.
- Stage 0 captures `man.rsp` when its data-load condition is met (see Configuration).
- Stage k captures stage k-1 under the same rule, applied to stage k-1's valid bit.
- `sub.rsp` is driven from the last stage.

Other rules:
- Write-only transfers still propagate `sts` and `err`. `rdt` is passed but carries no meaning.
- No field is modified, masked or byte-swapped.
- A `lck` sequence passes through transparently; the block does not track it.

## Timing
- Handshake: zero added latency; `sub.rdy` is a combinational copy of `man.rdy`.
- Response: valid on `sub` exactly `man.CFG.HSK.DLY + DLY_ADD` cycles after the handshake cycle.
- Throughput: one transfer per cycle sustained, with no bubbles.
- Stalls: while `man.rdy = 0` no transfer is accepted and no valid bits are injected. Responses already in flight continue to drain on schedule.

Reset values (cycle after `rst` sampled high):
- all tracking bits and stage valid bits: 0
- `sub.rsp.rdt`: 0
- `sub.rsp.sts`: 0
- `sub.rsp.err`: 0

Reset behaviour:
- Reset mid-operation discards every in-flight response. No response for a transfer handshaked before or during reset ever appears on `sub`.
- A handshake in the same cycle `rst` is high is not tracked.
- Reset deasserted: a transfer in the first cycle after deassertion is tracked normally.

## Configuration
Macro `TCB_LITE_LIB_RSP_HOLD_EN`:
- Defined: a stage's data registers load only when that stage's incoming valid bit is 1. `sub.rsp` therefore holds the last valid response between transfers, which reduces toggling.
- Undefined: data registers load unconditionally every cycle, and valid bits only gate tracking. `sub.rsp` outside valid cycles mirrors the delayed `man.rsp`, whatever its value.
- Latency and valid-cycle values are identical in both builds.

## Test plan
Default setup: `man.CFG.HSK.DLY = 1`, `DLY_ADD = 1` unless stated.

1. Single read of `adr = 0x10`; `man` returns `rdt = 0xDEADBEEF`, `err = 0` at handshake+1. Required: `sub.rsp.rdt = 0xDEADBEEF` at handshake+2.
2. Back-to-back reads of `0x0, 0x4, 0x8, 0xC` with `man.rdy = 1`; `man` returns `0x11, 0x22, 0x33, 0x44`. Required: the four values appear on `sub` in four consecutive cycles starting at the first handshake+2.
3. Read stalled by `man.rdy = 0` for 3 cycles. Required: `sub.rdy = 0` in those 3 cycles, no extra responses, and the response arrives 2 cycles after the actual handshake.
4. Write to `0x20` with `err = 1` returned. Required: `sub.rsp.err = 1` at handshake+2. With `DLY_ADD = 3`, the same result at handshake+4.
5. Three reads in flight, then `rst` asserted for 1 cycle. Required: `sub.rsp` = 0 after reset, and no stale response appears afterwards.
6. Built with `TCB_LITE_LIB_RSP_HOLD_EN`: read returns `0x5A5A5A5A`, then idle while `man.rsp.rdt` toggles. Required: `sub.rsp.rdt` stays `0x5A5A5A5A`. Without the macro it follows the delayed toggling.
